// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one data-bus transaction per memory op,
// with byte-lane steering, load formatting, pipeline stall and bus timeout.
module mem_stage_lsu #(
    parameter int datawidth = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_op,
    input  logic                 MEMRw,
    input  logic [datawidth-1:0] addr,
    input  logic [datawidth-1:0] store_data,
    input  logic [2:0]           Rsel,
    input  logic [1:0]           Wsel,
    output logic                 dmem_valid,
    output logic                 dmem_we,
    output logic [datawidth-1:0] dmem_addr,
    output logic [datawidth-1:0] dmem_wdata,
    output logic [3:0]           dmem_be,
    input  logic                 dmem_ready,
    input  logic [datawidth-1:0] dmem_rdata,
    output logic [datawidth-1:0] load_data,
    output logic                 stall,
    output logic                 misalign,
    output logic                 bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_q;
    logic           valid_q;
    logic           we_q;
    logic [3:0]     be_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [1:0]     off_q;
    logic [2:0]     rsel_q;
    logic [CW-1:0]  cnt_q;
    logic           err_q;
    logic [31:0]    load_q;

    logic           mis;
    logic [3:0]     be_d;
    logic [31:0]    wdata_d;
    logic [31:0]    lane;
    logic [31:0]    fmt;
    logic           start;

    always_comb begin
        mis     = 1'b0;
        be_d    = 4'b1111;
        wdata_d = store_data;
        if (MEMRw) begin
            unique case (Wsel)
                2'b00: begin
                    be_d    = 4'b0001 << addr[1:0];
                    wdata_d = {4{store_data[7:0]}};
                end
                2'b01: begin
                    mis     = addr[0];
                    be_d    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{store_data[15:0]}};
                end
                default: mis = |addr[1:0];
            endcase
        end else begin
            unique case (Rsel)
                3'b000, 3'b100: mis = 1'b0;
                3'b001, 3'b101: mis = addr[0];
                default:        mis = |addr[1:0];
            endcase
        end
    end

    // Lane select then sign/zero extension of the returned word
    always_comb begin
        lane = dmem_rdata >> {off_q, 3'b000};
        unique case (rsel_q)
            3'b000:  fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  fmt = {24'h0, lane[7:0]};
            3'b101:  fmt = {16'h0, lane[15:0]};
            default: fmt = dmem_rdata;
        endcase
    end

    assign start = (state_q == IDLE) && mem_op && !mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            off_q   <= 2'b00;
            rsel_q  <= 3'b000;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= BUSY;
                        valid_q <= 1'b1;
                        we_q    <= MEMRw;
                        be_q    <= be_d;
                        addr_q  <= {addr[31:2], 2'b00};
                        wdata_q <= wdata_d;
                        off_q   <= addr[1:0];
                        rsel_q  <= Rsel;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        if (!we_q) load_q <= fmt;
                        state_q <= DONE;
                        valid_q <= 1'b0;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        load_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                        valid_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_valid = valid_q;
    assign dmem_we    = valid_q & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign load_data  = load_q;
    assign bus_err    = err_q;
    // Gated by rst so the pipeline is released the instant reset hits
    assign stall      = rst & (start | (state_q == BUSY));
    assign misalign   = rst & (state_q == IDLE) & mem_op & mis;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: random loads/stores, random bus latency,
// timeouts, misalignment and an asynchronous reset mid-transaction.
module tb_mem_stage_lsu;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_op = 1'b0;
    logic        MEMRw = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic [2:0]  Rsel = '0;
    logic [1:0]  Wsel = '0;
    logic        dmem_valid;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    mem_stage_lsu #(.datawidth(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_op(mem_op), .MEMRw(MEMRw),
        .addr(addr), .store_data(store_data), .Rsel(Rsel), .Wsel(Wsel),
        .dmem_valid(dmem_valid), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .load_data(load_data), .stall(stall),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          misal;
        logic [31:0] ld;
        bit          err;
        int          vcyc;
    } res_t;

    typedef struct {
        logic [31:0] a;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    res_t rq[$];
    bus_t bq[$];

    int          ncmp = 0;
    int          nerr = 0;
    bit          mon_en = 1'b1;
    int          rsp_d = 0;
    logic [31:0] rsp_rd = '0;
    logic [31:0] mdl_load = '0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic finish_up();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    endtask

    // Bus slave: ready after rsp_d wait cycles; ready toggles randomly when idle
    int vcnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (dmem_valid) begin
                dmem_ready = (vcnt >= rsp_d);
                dmem_rdata = dmem_ready ? rsp_rd : $urandom;
                vcnt++;
            end else begin
                vcnt = 0;
                dmem_ready = 1'($urandom);
                dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents something
    bit pv = 1'b0;
    int mvc = 0;
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (misalign) begin
                if (rq.size() == 0) begin
                    ncmp++; nerr++;
                    $display("FAIL misalign_unexpected: got 1 expected none");
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    chk("misal_flag", 32'(r.misal), 32'd1);
                    chk("misal_stall", 32'(stall), 32'd0);
                    chk("misal_valid", 32'(dmem_valid), 32'd0);
                    chk("misal_load", load_data, r.ld);
                end
            end
            if (dmem_valid) begin
                if (!pv) begin
                    mvc = 1;
                    if (bq.size() == 0) begin
                        ncmp++; nerr++;
                        $display("FAIL bus_unexpected: got valid expected none");
                    end else begin
                        bus_t b;
                        b = bq.pop_front();
                        chk("bus_addr", dmem_addr, b.a);
                        chk("bus_we", 32'(dmem_we), 32'(b.we));
                        chk("bus_be", 32'(dmem_be), 32'(b.be));
                        if (b.we) chk("bus_wdata", dmem_wdata, b.wd);
                    end
                end else begin
                    mvc++;
                end
            end else if (pv) begin
                if (rq.size() == 0) begin
                    ncmp++; nerr++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    chk("done_misal", 32'(r.misal), 32'd0);
                    chk("done_load", load_data, r.ld);
                    chk("done_err", 32'(bus_err), 32'(r.err));
                    chk("done_vcyc", 32'(mvc), 32'(r.vcyc));
                    chk("done_stall", 32'(stall), 32'd0);
                end
            end
            pv = dmem_valid;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic do_op(input bit st, input logic [31:0] a,
                         input logic [31:0] sd, input logic [2:0] rs,
                         input logic [1:0] ws, input int d,
                         input logic [31:0] rd);
        int size;
        int off;
        bit mis;
        bus_t b;
        res_t r;
        logic [31:0] lane;
        byte sb;
        shortint sh;
        int k;
        mem_op = 1'b1; MEMRw = st; addr = a; store_data = sd;
        Rsel = rs; Wsel = ws; rsp_d = d; rsp_rd = rd;
        if (st) size = (ws == 2'd0) ? 1 : (ws == 2'd1) ? 2 : 4;
        else if (rs == 3'd0 || rs == 3'd4) size = 1;
        else if (rs == 3'd1 || rs == 3'd5) size = 2;
        else size = 4;
        off = int'(a % 4);
        mis = (a % size) != 0;
        if (mis) begin
            r = '{1'b1, mdl_load, 1'b0, 0};
            rq.push_back(r);
            @(posedge clk); #1;
            mem_op = 1'b0;
            return;
        end
        b.a  = a & ~32'd3;
        b.we = st;
        b.be = st ? 4'(((1 << size) - 1) << off) : 4'hF;
        b.wd = (size == 1) ? {4{sd[7:0]}} : (size == 2) ? {2{sd[15:0]}} : sd;
        bq.push_back(b);
        lane = rd >> (8 * off);
        if (d >= TO) begin
            r = '{1'b0, 32'h0, 1'b1, TO};
        end else begin
            r = '{1'b0, mdl_load, 1'b0, d + 1};
            if (!st) begin
                if (size == 1) begin
                    sb = lane[7:0];
                    r.ld = rs[2] ? {24'h0, lane[7:0]} : 32'(int'(sb));
                end else if (size == 2) begin
                    sh = lane[15:0];
                    r.ld = rs[2] ? {16'h0, lane[15:0]} : 32'(int'(sh));
                end else begin
                    r.ld = rd;
                end
            end
        end
        rq.push_back(r);
        mdl_load = r.ld;
        @(posedge clk); #1;
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (!stall) break;
        end
        if (k == 100) begin
            ncmp++; nerr++;
            $display("FAIL stall_timeout: got stall stuck expected release");
            finish_up();
        end
        @(posedge clk); #1;
        mem_op = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(dmem_valid), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_op(1'b0, 32'h100, 32'h0, 3'b010, 2'b00, 0, 32'hDEADBEEF);
        do_op(1'b0, 32'h203, 32'h0, 3'b000, 2'b00, 0, 32'h80112233);
        do_op(1'b0, 32'h203, 32'h0, 3'b100, 2'b00, 0, 32'h80112233);
        do_op(1'b1, 32'h306, 32'h0000ABCD, 3'b000, 2'b01, 0, 32'h0);
        do_op(1'b0, 32'h102, 32'h0, 3'b010, 2'b00, 0, 32'h0);
        do_op(1'b1, 32'h400, 32'h12345678, 3'b000, 2'b10, 20, 32'h0);
        do_op(1'b0, 32'h502, 32'h0, 3'b001, 2'b00, 15, 32'h8001F00F);
        do_op(1'b0, 32'h502, 32'h0, 3'b101, 2'b00, 3, 32'h8001F00F);
        do_op(1'b1, 32'h601, 32'hAABBCCDD, 3'b000, 2'b11, 0, 32'h0);

        for (int i = 0; i < 150; i++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 4))
                                            : int'($urandom_range(0, 4));
            do_op(1'($urandom), $urandom, $urandom, 3'($urandom),
                  2'($urandom), d, $urandom);
            repeat ($urandom_range(0, 2)) begin
                addr = $urandom;
                Rsel = 3'($urandom);
                @(posedge clk); #1;
            end
        end

        do_op(1'b0, 32'h700, 32'h0, 3'b010, 2'b00, 0, 32'hCAFEF00D);
        repeat (2) @(posedge clk);
        #1;
        chk("q_res_empty", 32'(rq.size()), 32'd0);
        chk("q_bus_empty", 32'(bq.size()), 32'd0);

        mon_en = 1'b0;
        mem_op = 1'b1; MEMRw = 1'b0; addr = 32'h104; Rsel = 3'b010;
        rsp_d = 3; rsp_rd = 32'h11111111;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("pre_rst_valid", 32'(dmem_valid), 32'd1);
        chk("pre_rst_load", load_data, 32'hCAFEF00D);
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(dmem_valid), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_load", load_data, 32'd0);
        chk("arst_be", 32'(dmem_be), 32'd0);
        chk("arst_we", 32'(dmem_we), 32'd0);
        mem_op = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_idle", 32'(dmem_valid), 32'd0);
        end

        mdl_load = 32'h0;
        mon_en = 1'b1;
        do_op(1'b0, 32'h42, 32'h0, 3'b101, 2'b00, 1, 32'h9876ABCD);
        repeat (2) @(posedge clk);
        #1;
        chk("end_res_empty", 32'(rq.size()), 32'd0);
        chk("end_bus_empty", 32'(bq.size()), 32'd0);
        finish_up();
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit on the consumer side of the EX/MEM pipeline register.
- Takes the registered ALU result (address), store data, MEMRw, Rsel and Wsel, and runs one data-memory bus transaction per memory op using a valid/ready handshake.
- Returns aligned, sign/zero-extended load data for writeback.
- Drives a stall that deasserts the enable of EX/MEM and all earlier pipeline registers until the access completes.

Parameters:
- datawidth, 32, data/address width; only 32 is supported.
- TIMEOUT, 16, maximum number of BUSY cycles waiting for dmem_ready before the access is aborted with a bus error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_op  input  1  EX/MEM holds a valid load or store this cycle.
- MEMRw  input  1  1 = store, 0 = load.
- addr  input  datawidth  byte address (ALU_out from EX/MEM).
- store_data  input  datawidth  rs2 value (datareg_out from EX/MEM).
- Rsel  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are treated as LW.
- Wsel  input  2  store type: 00 SB, 01 SH, 10 SW; code 11 is treated as SW.
- dmem_valid  output  1  bus request valid.
- dmem_we  output  1  bus write enable.
- dmem_addr  output  datawidth  word-aligned address (addr[1:0] forced to 00).
- dmem_wdata  output  datawidth  lane-replicated store data.
- dmem_be  output  4  byte enables.
- dmem_ready  input  1  bus accepts/completes the access in the cycle where dmem_valid && dmem_ready.
- dmem_rdata  input  datawidth  read word; valid in the cycle dmem_valid && dmem_ready.
- load_data  output  datawidth  formatted load result (registered).
- stall  output  1  hold pipeline; the EX/MEM enable is the inverse of this signal.
- misalign  output  1  misaligned access detected (combinational, IDLE only).
- bus_err  output  1  one-cycle pulse in DONE when the access timed out.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; dmem_valid, dmem_we and bus_err = 0; dmem_be = 0; load_data = 0; timeout counter = 0.
  - A transaction in flight is abandoned immediately, with no completion.
- FSM states: IDLE, BUSY, DONE.
- Misalignment rule: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 00.
- IDLE:
  - If mem_op && misaligned: misalign = 1, stall = 0, no bus access, load_data unchanged, stay in IDLE.
  - If mem_op && aligned: stall = 1. Latch word address, we = MEMRw, byte enables, write data, addr[1:0] and Rsel into internal registers. Next state BUSY, counter cleared.
  - Otherwise stall = 0.
- BUSY:
  - dmem_valid = 1; the bus outputs come from the latched registers and are stable for the whole state; stall = 1.
  - If dmem_ready: for a load, load_data is updated with the formatted dmem_rdata; for a store, load_data is unchanged. Next state DONE.
  - Else if the counter equals TIMEOUT-1: load_data = 0, set the error flag, next state DONE.
  - Else the counter increments.
- DONE:
  - stall = 0, dmem_valid = 0, bus_err = error flag; flag cleared on exit; next state IDLE.
  - The pipeline advances at the end of this cycle, so the same op is never re-issued.
- Minimum latency with dmem_ready held high: 2 stall cycles (IDLE, BUSY); load_data is valid in DONE.
- Byte enables and write data:
  - SB: be = 0001 << addr[1:0], wdata = {4{store_data[7:0]}}.
  - SH: be = 0011 << (2*addr[1]), wdata = {2{store_data[15:0]}}.
  - SW: be = 1111, wdata = store_data.
  - Loads drive be = 1111.
- Load formatting:
  - Selected lane = dmem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- A dmem_ready asserted while dmem_valid = 0 is ignored.
- The TIMEOUT check and ready are evaluated in the same cycle; ready wins.

Test Plan:
- LW addr 0x100, ready high, rdata 0xDEADBEEF → dmem_valid for 1 cycle with dmem_addr 0x100 and be 1111; stall high for 2 cycles; load_data = 0xDEADBEEF in DONE.
- LB addr 0x203, rdata 0x80112233 → be 1111, dmem_addr 0x200, load_data = 0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH addr 0x306, store_data 0x0000ABCD → dmem_we = 1, be = 1100, wdata = 0xABCDABCD; load_data unchanged.
- LW addr 0x102 → misalign = 1 for one cycle, stall = 0, dmem_valid never asserted.
- SW with ready held low and TIMEOUT = 16 → dmem_valid high for exactly 16 cycles, then bus_err pulse in DONE and stall released.
- LW with ready delayed 3 cycles, rst pulsed low in the 2nd BUSY cycle → dmem_valid and stall drop immediately; state returns to IDLE; load_data = 0.
